// File: rtl/baud_gen_frac_if.sv
// Divisor/resync bus and tick-enable outputs between the UART
// register block (master) and the fractional baud generator (slave).
interface baud_gen_frac_if #(
  parameter int INT_WIDTH  = 16,
  parameter int FRAC_WIDTH = 4,
  parameter int OVERSAMPLE = 16
);
  localparam int PW = $clog2(OVERSAMPLE);

  logic [INT_WIDTH-1:0]  div_int;
  logic [FRAC_WIDTH-1:0] div_frac;
  logic                  div_load;
  logic                  rx_resync;
  logic                  rxclk_en;
  logic                  txclk_en;
  logic [PW-1:0]         rx_phase;

  modport master (
    output div_int, div_frac, div_load, rx_resync,
    input  rxclk_en, txclk_en, rx_phase
  );

  modport slave (
    input  div_int, div_frac, div_load, rx_resync,
    output rxclk_en, txclk_en, rx_phase
  );
endinterface

// File: rtl/baud_gen_frac.sv
// Fractional-N baud generator: one loadable divisor feeding an RX tick
// engine (re-phasable) and a free-running TX tick engine.
module baud_gen_frac #(
  parameter int CLOCK_FREQ = 62500000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int INT_WIDTH  = 16,
  parameter int FRAC_WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable,
  baud_gen_frac_if.slave bus
);
  localparam int PW = $clog2(OVERSAMPLE);
  localparam int CW = INT_WIDTH + 1;
  localparam logic [63:0] RST_DIV =
    (64'(CLOCK_FREQ) << FRAC_WIDTH) /
    (64'(BAUD_RATE) * 64'(OVERSAMPLE));
  localparam logic [INT_WIDTH-1:0] RST_I =
    RST_DIV[FRAC_WIDTH +: INT_WIDTH];
  localparam logic [FRAC_WIDTH-1:0] RST_F =
    RST_DIV[FRAC_WIDTH-1:0];
  localparam logic [PW-1:0] PH_MAX = PW'(OVERSAMPLE - 1);

  logic [INT_WIDTH-1:0]  div_i, sel_i, use_i;
  logic [FRAC_WIDTH-1:0] div_f, sel_f, use_f;
  logic [FRAC_WIDTH-1:0] rx_acc, tx_acc, rx_base;
  logic [FRAC_WIDTH:0]   rx_sum, tx_sum;
  logic [CW-1:0]         rx_cnt, tx_cnt;
  logic [CW-1:0]         rld_cnt, rx_new, tx_new;
  logic [PW-1:0]         rx_ph, tx_os;
  logic                  run_q, rx_en, tx_en;
  logic                  rx_zero, tx_zero;
  logic                  rx_tick, tx_tick;
  logic                  rx_rld, tx_rld;

  assign bus.rxclk_en = rx_en;
  assign bus.txclk_en = tx_en;
  assign bus.rx_phase = rx_ph;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_i <= RST_I;
      div_f <= RST_F;
    end else if (bus.div_load) begin
      div_i <= bus.div_int;
      div_f <= bus.div_frac;
    end
  end

  // A load coinciding with a reload takes effect in that reload.
  always_comb begin
    sel_i = bus.div_load ? bus.div_int : div_i;
    sel_f = bus.div_load ? bus.div_frac : div_f;
    use_i = sel_i;
    use_f = sel_f;
    if (sel_i < INT_WIDTH'(2)) begin
      use_i = INT_WIDTH'(2);
      use_f = '0;
    end
    rld_cnt = CW'(use_i) - CW'(1);
  end

  // run_q low marks the first enabled edge, which acts as a reload.
  always_comb begin
    rx_base = bus.rx_resync ? '0 : rx_acc;
    rx_sum  = {1'b0, rx_base} + {1'b0, use_f};
    tx_sum  = {1'b0, tx_acc} + {1'b0, use_f};
    rx_new  = rld_cnt + CW'(rx_sum[FRAC_WIDTH]);
    tx_new  = rld_cnt + CW'(tx_sum[FRAC_WIDTH]);
    rx_zero = (rx_cnt == '0);
    tx_zero = (tx_cnt == '0);
    rx_tick = run_q && rx_zero && !bus.rx_resync;
    tx_tick = run_q && tx_zero;
    rx_rld  = !run_q || rx_zero || bus.rx_resync;
    tx_rld  = !run_q || tx_zero;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      rx_cnt <= '0;
      rx_acc <= '0;
      rx_ph  <= '0;
      rx_en  <= 1'b0;
    end else if (!enable) begin
      run_q  <= 1'b0;
      rx_cnt <= rld_cnt;
      rx_acc <= '0;
      rx_ph  <= '0;
      rx_en  <= 1'b0;
    end else begin
      run_q <= 1'b1;
      rx_en <= rx_tick;
      if (rx_rld) begin
        rx_acc <= rx_sum[FRAC_WIDTH-1:0];
        rx_cnt <= rx_new;
      end else begin
        rx_cnt <= rx_cnt - CW'(1);
      end
      if (bus.rx_resync)
        rx_ph <= '0;
      else if (rx_tick)
        rx_ph <= (rx_ph == PH_MAX) ? '0 : rx_ph + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt <= '0;
      tx_acc <= '0;
      tx_os  <= '0;
      tx_en  <= 1'b0;
    end else if (!enable) begin
      tx_cnt <= rld_cnt;
      tx_acc <= '0;
      tx_os  <= '0;
      tx_en  <= 1'b0;
    end else begin
      tx_en <= tx_tick && (tx_os == PH_MAX);
      if (tx_rld) begin
        tx_acc <= tx_sum[FRAC_WIDTH-1:0];
        tx_cnt <= tx_new;
      end else begin
        tx_cnt <= tx_cnt - CW'(1);
      end
      if (tx_tick)
        tx_os <= (tx_os == PH_MAX) ? '0 : tx_os + PW'(1);
    end
  end
endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed bench for baud_gen_frac: pulse times are logged per cycle
// and compared against hand-computed cycle offsets.
module tb_baud_gen_frac;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   rx_q[$];
  int   ph_q[$];
  int   tx_q[$];
  bit   rx_prev = 0;
  bit   tx_prev = 0;
  int   dbl = 0;
  int   r0, e0, s0;
  bit   found;

  baud_gen_frac_if bus ();

  baud_gen_frac dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      if (bus.rxclk_en) begin
        rx_q.push_back(cyc);
        ph_q.push_back(int'(bus.rx_phase));
      end
      if (bus.txclk_en) tx_q.push_back(cyc);
      if (bus.rxclk_en && rx_prev) dbl++;
      if (bus.txclk_en && tx_prev) dbl++;
      rx_prev = bus.rxclk_en;
      tx_prev = bus.txclk_en;
    end
  endtask

  task automatic clr();
    rx_q.delete();
    ph_q.delete();
    tx_q.delete();
  endtask

  function automatic int qa(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic int bad_iv(input int q[$], input int lo,
                                input int hi, input int n);
    int b = 0;
    if (q.size() < n + 1) return -1;
    for (int i = 0; i < n; i++)
      if (q[i+1] - q[i] < lo || q[i+1] - q[i] > hi) b++;
    return b;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load(input int i, input int f);
    bus.div_int  = 16'(i);
    bus.div_frac = 4'(f);
    bus.div_load = 1'b1;
    step(1);
    bus.div_load = 1'b0;
  endtask

  initial begin
    bus.div_int   = '0;
    bus.div_frac  = '0;
    bus.div_load  = 1'b0;
    bus.rx_resync = 1'b0;
    step(3);
    chk("rst_rxen", int'(bus.rxclk_en), 0);
    chk("rst_txen", int'(bus.txclk_en), 0);
    chk("rst_phase", int'(bus.rx_phase), 0);

    // reset divisor 33 + 14/16
    rst_n = 1'b1;
    r0 = cyc;
    clr();
    step(34 + 8672 + 4);
    chk("rd_first", qa(rx_q, 0) - r0, 34);
    chk("rd_first_ph", qa(ph_q, 0), 1);
    chk("rd_iv_33_34", bad_iv(rx_q, 33, 34, 256), 0);
    chk("rd_span256", qa(rx_q, 256) - qa(rx_q, 0), 8672);
    chk("rd_tx_at16", qa(tx_q, 0), qa(rx_q, 15));
    chk("rd_ph16", qa(ph_q, 15), 0);
    chk("rd_tx_iv", qa(tx_q, 1) - qa(tx_q, 0), 542);

    // integer divisor 4, loaded while disabled for 20 cycles
    enable = 1'b0;
    clr();
    load(4, 0);
    step(19);
    chk("dis_rx", rx_q.size(), 0);
    chk("dis_tx", tx_q.size(), 0);
    chk("dis_phase", int'(bus.rx_phase), 0);
    enable = 1'b1;
    e0 = cyc;
    clr();
    step(135);
    chk("i4_first", qa(rx_q, 0) - e0, 5);
    chk("i4_iv", bad_iv(rx_q, 4, 4, 31), 0);
    chk("i4_ph15", qa(ph_q, 14), 15);
    chk("i4_wrap", qa(ph_q, 15), 0);
    chk("i4_tx_at16", qa(tx_q, 0), qa(rx_q, 15));
    chk("i4_tx_iv", qa(tx_q, 1) - qa(tx_q, 0), 64);

    // fractional divisor 4.5
    enable = 1'b0;
    load(4, 8);
    step(1);
    enable = 1'b1;
    e0 = cyc;
    clr();
    step(160);
    chk("f_first", qa(rx_q, 0) - e0, 5);
    chk("f_iv1", qa(rx_q, 1) - qa(rx_q, 0), 5);
    chk("f_iv2", qa(rx_q, 2) - qa(rx_q, 1), 4);
    chk("f_span32", qa(rx_q, 32) - qa(rx_q, 0), 144);

    // resync mid-period, then resync on a tick edge, I=10
    enable = 1'b0;
    load(10, 0);
    step(1);
    enable = 1'b1;
    e0 = cyc;
    clr();
    step(16);
    s0 = cyc;
    bus.rx_resync = 1'b1;
    step(1);
    bus.rx_resync = 1'b0;
    step(19);
    bus.rx_resync = 1'b1;
    step(1);
    bus.rx_resync = 1'b0;
    step(300);
    chk("rs_pre", qa(rx_q, 0) - e0, 11);
    chk("rs_lat", qa(rx_q, 1) - s0, 11);
    chk("rs_ph", qa(ph_q, 1), 1);
    chk("rs_tick_lat", qa(rx_q, 2) - s0, 31);
    chk("rs_tick_ph", qa(ph_q, 2), 1);
    chk("rs_iv", qa(rx_q, 3) - qa(rx_q, 2), 10);
    chk("rs_tx0", qa(tx_q, 0) - e0, 161);
    chk("rs_tx_iv", qa(tx_q, 1) - qa(tx_q, 0), 160);

    // load 8 while running with 4 and cnt at 2
    enable = 1'b0;
    load(4, 0);
    step(1);
    enable = 1'b1;
    e0 = cyc;
    clr();
    step(2);
    load(8, 0);
    step(25);
    chk("mc_p0", qa(rx_q, 0) - e0, 5);
    chk("mc_p1", qa(rx_q, 1) - e0, 13);
    chk("mc_p2", qa(rx_q, 2) - e0, 21);

    // clamp: I=1 runs as I=2, F=0
    enable = 1'b0;
    load(1, 5);
    step(1);
    enable = 1'b1;
    e0 = cyc;
    clr();
    step(10);
    chk("cl_first", qa(rx_q, 0) - e0, 3);
    chk("cl_iv1", qa(rx_q, 1) - qa(rx_q, 0), 2);
    chk("cl_iv2", qa(rx_q, 2) - qa(rx_q, 1), 2);

    // async reset while a pulse is high
    found = 0;
    for (int k = 0; k < 8 && !found; k++) begin
      step(1);
      if (bus.rxclk_en) found = 1;
    end
    chk("ar_found", int'(found), 1);
    rst_n = 1'b0;
    #1;
    chk("ar_rxen", int'(bus.rxclk_en), 0);
    chk("ar_txen", int'(bus.txclk_en), 0);
    chk("ar_phase", int'(bus.rx_phase), 0);
    step(2);
    rst_n = 1'b1;
    r0 = cyc;
    clr();
    step(72);
    chk("ar_first", qa(rx_q, 0) - r0, 34);
    chk("ar_iv", qa(rx_q, 1) - qa(rx_q, 0), 34);

    chk("no_back2back", dbl, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
